// File: rtl/qoi_stream_framer_pkg.sv
// Shared types and constants for the QOI stream framer.
// Header byte order and register addresses live here.
package qoi_types;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY,
        TRAILER,
        DONE
    } framer_state_t;

    localparam logic [31:0] QOI_MAGIC   = 32'h716F6966;
    localparam int          QOI_END_LEN = 8;
    localparam int          QOI_HDR_LEN = 14;

    localparam addr_t REG_FIFO = 3'd0;
    localparam addr_t REG_STAT = 3'd1;
    localparam addr_t REG_CTRL = 3'd2;
    localparam addr_t REG_WLO  = 3'd3;
    localparam addr_t REG_WHI  = 3'd4;
    localparam addr_t REG_HLO  = 3'd5;
    localparam addr_t REG_HHI  = 3'd6;
    localparam addr_t REG_CNT  = 3'd7;

    // Byte idx of the 14-byte header; unnamed slots are zero.
    function automatic byte_t hdr_byte(
        input logic [3:0]  idx,
        input logic [15:0] w,
        input logic [15:0] h,
        input logic        ch4,
        input logic        csb
    );
        case (idx)
            4'd0:    hdr_byte = QOI_MAGIC[31:24];
            4'd1:    hdr_byte = QOI_MAGIC[23:16];
            4'd2:    hdr_byte = QOI_MAGIC[15:8];
            4'd3:    hdr_byte = QOI_MAGIC[7:0];
            4'd6:    hdr_byte = w[15:8];
            4'd7:    hdr_byte = w[7:0];
            4'd10:   hdr_byte = h[15:8];
            4'd11:   hdr_byte = h[7:0];
            4'd12:   hdr_byte = ch4 ? 8'h04 : 8'h03;
            4'd13:   hdr_byte = {7'b0, csb};
            default: hdr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/qoi_stream_framer_if.sv
// Bus window and encoder stream bundle for the framer.
// master = host/encoder side, slave = framer.
interface qoi_stream_framer_if;

    logic                cs;
    logic                we;
    qoi_types::addr_t    addr;
    qoi_types::byte_t    data_i;
    qoi_types::byte_t    data_o;
    qoi_types::byte_t    enc_data;
    logic                enc_valid;
    logic                enc_last;
    logic                enc_ready;

    modport master (
        output cs, we, addr, data_i,
        output enc_data, enc_valid, enc_last,
        input  data_o, enc_ready
    );

    modport slave (
        input  cs, we, addr, data_i,
        input  enc_data, enc_valid, enc_last,
        output data_o, enc_ready
    );

endinterface

// File: rtl/qoi_stream_framer_fifo.sv
// Byte FIFO with first-word-fall-through read.
// Push is refused when full even if a pop lands the same cycle.
module qoi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rp];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qoi_stream_framer.sv
// Wraps encoder bytes in a QOI header and end marker, buffered in a
// FIFO that the host drains through an 8-register bus window.
module qoi_stream_framer
    import qoi_types::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    qoi_stream_framer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    framer_state_t state;
    logic [3:0]    idx;
    logic [15:0]   width;
    logic [15:0]   height;
    logic          ch4;
    logic          cs_bit;

    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    byte_t         head;
    byte_t         din;
    logic          push;
    logic          pop;
    logic          busy;
    logic          done;
    logic          wr;
    logic          start;

    assign busy  = (state == HEADER) | (state == BODY) | (state == TRAILER);
    assign done  = (state == DONE);
    assign wr    = bus.cs & bus.we & ~busy;
    assign start = wr & (bus.addr == REG_CTRL) & bus.data_i[7];
    assign pop   = bus.cs & ~bus.we & (bus.addr == REG_FIFO);

    assign bus.enc_ready = (state == BODY) & ~full;

    always_comb begin
        push = 1'b0;
        din  = hdr_byte(idx, width, height, ch4, cs_bit);
        case (state)
            HEADER:  push = ~full;
            BODY: begin
                push = bus.enc_valid & ~full;
                din  = bus.enc_data;
            end
            TRAILER: begin
                push = ~full;
                din  = {7'b0, idx == 4'(QOI_END_LEN - 1)};
            end
            default: push = 1'b0;
        endcase
    end

    qoi_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            width  <= '0;
            height <= '0;
            ch4    <= 1'b0;
            cs_bit <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.addr)
                    REG_CTRL: {ch4, cs_bit} <= bus.data_i[6:5];
                    REG_WLO:  width[7:0]    <= bus.data_i;
                    REG_WHI:  width[15:8]   <= bus.data_i;
                    REG_HLO:  height[7:0]   <= bus.data_i;
                    REG_HHI:  height[15:8]  <= bus.data_i;
                    default:  ;
                endcase
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= HEADER;
                        idx   <= '0;
                    end
                end
                HEADER: begin
                    if (!full) begin
                        if (idx == 4'(QOI_HDR_LEN - 1)) begin
                            state <= BODY;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                BODY: begin
                    if (push && bus.enc_last) begin
                        state <= TRAILER;
                        idx   <= '0;
                    end
                end
                TRAILER: begin
                    if (!full) begin
                        if (idx == 4'(QOI_END_LEN - 1)) begin
                            state <= DONE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads never have side effects except the pop at REG_FIFO.
    always_comb begin
        case (bus.addr)
            REG_FIFO: bus.data_o = empty ? 8'h00 : head;
            REG_STAT: bus.data_o = {busy, done, 4'b0, full, ~empty};
            REG_WLO:  bus.data_o = width[7:0];
            REG_WHI:  bus.data_o = width[15:8];
            REG_HLO:  bus.data_o = height[7:0];
            REG_HHI:  bus.data_o = height[15:8];
            REG_CNT:  bus.data_o = 8'(count);
            default:  bus.data_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_qoi_stream_framer.sv
// Directed self-checking bench for qoi_stream_framer.
module tb_qoi_stream_framer;
    import qoi_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    byte_t got [0:63];

    qoi_stream_framer_if bus ();

    qoi_stream_framer #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input addr_t a, input byte_t d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic read_reg(input addr_t a, output byte_t d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1 d = bus.data_o;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.enc_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_byte(input byte_t d, input logic last, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.enc_valid = 1'b1; bus.enc_data = d; bus.enc_last = last;
        for (int i = 0; i < 200; i++) begin
            if (bus.enc_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.enc_valid = 1'b0; bus.enc_last = 1'b0;
    endtask

    task automatic drain(input int want, output int n);
        n = 0;
        for (int i = 0; i < 400 && n < want; i++) begin
            @(negedge clk);
            bus.cs = 1'b1; bus.we = 1'b0; bus.addr = REG_STAT;
            #1;
            if (bus.data_o[0]) begin
                bus.addr = REG_FIFO;
                #1;
                got[n] = bus.data_o;
                n++;
            end else begin
                bus.cs = 1'b0;
            end
        end
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic test_reset();
        byte_t d;
        do_reset();
        read_reg(REG_STAT, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", d); end
        read_reg(REG_CNT, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", d); end
        read_reg(REG_FIFO, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_head got=%h exp=00", d); end
        checks++;
        if (bus.enc_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.enc_ready); end
    endtask

    task automatic test_frame();
        byte_t exp [24];
        bit ok;
        int n;
        byte_t d;
        exp = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h00, 8'h55, 8'hAA,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        do_reset();
        bus_write(REG_WLO, 8'h02);
        bus_write(REG_WHI, 8'h00);
        bus_write(REG_HLO, 8'h01);
        bus_write(REG_HHI, 8'h00);
        bus_write(REG_CTRL, 8'hC0);
        send_byte(8'h55, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_send55 got=timeout exp=accept"); end
        send_byte(8'hAA, 1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_sendAA got=timeout exp=accept"); end
        drain(24, n);
        checks++;
        if (n !== 24) begin failures++; $display("FAIL frame_len got=%0d exp=24", n); end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL frame_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        read_reg(REG_STAT, d);
        checks++;
        if (d !== 8'h40) begin failures++; $display("FAIL frame_status got=%h exp=40", d); end
    endtask

    task automatic test_full();
        byte_t exp [25];
        byte_t nxt;
        byte_t d;
        int n;
        exp = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h00, 8'h10, 8'h11,
                8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h01};
        do_reset();
        bus_write(REG_WLO, 8'h01);
        bus_write(REG_HLO, 8'h01);
        bus_write(REG_CTRL, 8'h80);
        nxt = 8'h10;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.enc_valid = 1'b1; bus.enc_last = 1'b0; bus.enc_data = nxt;
            if (bus.enc_ready) nxt = nxt + 8'd1;
        end
        read_reg(REG_CNT, d);
        checks++;
        if (d !== 8'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", d); end
        read_reg(REG_STAT, d);
        checks++;
        if (d !== 8'h83) begin failures++; $display("FAIL full_status got=%h exp=83", d); end
        checks++;
        if (bus.enc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.enc_ready); end
        read_reg(REG_FIFO, d);
        checks++;
        if (d !== exp[0]) begin failures++; $display("FAIL full_pop got=%h exp=%h", d, exp[0]); end
        checks++;
        if (bus.enc_ready !== 1'b1) begin failures++; $display("FAIL full_reraise got=%b exp=1", bus.enc_ready); end
        checks++;
        if (nxt !== 8'h12) begin failures++; $display("FAIL full_accepted got=%h exp=12", nxt); end
        bus.enc_data = nxt; bus.enc_last = 1'b1;
        @(negedge clk);
        bus.enc_valid = 1'b0; bus.enc_last = 1'b0;
        drain(24, n);
        checks++;
        if (n !== 24) begin failures++; $display("FAIL full_len got=%0d exp=24", n); end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (got[i] !== exp[i+1]) begin
                failures++;
                $display("FAIL full_byte%0d got=%h exp=%h", i + 1, got[i], exp[i+1]);
            end
        end
    endtask

    task automatic test_empty_read();
        byte_t d;
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            read_reg(REG_FIFO, d);
            checks++;
            if (d !== 8'h00) begin failures++; $display("FAIL empty_read%0d got=%h exp=00", i, d); end
        end
        read_reg(REG_CNT, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL empty_count got=%h exp=00", d); end
        bus_write(REG_CTRL, 8'h80);
        drain(1, n);
        checks++;
        if (n !== 1 || got[0] !== 8'h71) begin
            failures++;
            $display("FAIL empty_nextpush got=%h n=%0d exp=71", got[0], n);
        end
    endtask

    task automatic test_push_pop();
        byte_t exp [5];
        byte_t d;
        bit ok;
        int n;
        exp = '{8'h05, 8'h06, 8'h04, 8'h01, 8'hA5};
        do_reset();
        bus_write(REG_WLO, 8'h04);
        bus_write(REG_WHI, 8'h03);
        bus_write(REG_HLO, 8'h06);
        bus_write(REG_HHI, 8'h05);
        bus_write(REG_CTRL, 8'hE0);
        wait_ready(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL pp_body got=timeout exp=ready"); end
        for (int i = 0; i < 9; i++) read_reg(REG_FIFO, d);
        read_reg(REG_CNT, d);
        checks++;
        if (d !== 8'd5) begin failures++; $display("FAIL pp_count_pre got=%0d exp=5", d); end
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = REG_FIFO;
        bus.enc_valid = 1'b1; bus.enc_data = 8'hA5; bus.enc_last = 1'b0;
        #1;
        d = bus.data_o;
        ok = bus.enc_ready;
        @(negedge clk);
        bus.cs = 1'b0; bus.enc_valid = 1'b0;
        checks++;
        if (d !== 8'h00 || !ok) begin failures++; $display("FAIL pp_same_cycle got=%h/%b exp=00/1", d, ok); end
        read_reg(REG_CNT, d);
        checks++;
        if (d !== 8'd5) begin failures++; $display("FAIL pp_count_post got=%0d exp=5", d); end
        drain(5, n);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL pp_order%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        byte_t exp [23];
        byte_t d;
        bit ok;
        int n;
        exp = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h10,
                8'h00, 8'h00, 8'h00, 8'h20, 8'h03, 8'h00, 8'h3C,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        do_reset();
        bus_write(REG_WLO, 8'h10);
        bus_write(REG_HLO, 8'h20);
        bus_write(REG_CTRL, 8'h80);
        wait_ready(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL busy_body got=timeout exp=ready"); end
        bus_write(REG_WLO, 8'h77);
        bus_write(REG_CTRL, 8'hC0);
        read_reg(REG_WLO, d);
        checks++;
        if (d !== 8'h10) begin failures++; $display("FAIL busy_width got=%h exp=10", d); end
        read_reg(REG_STAT, d);
        checks++;
        if (d !== 8'h81) begin failures++; $display("FAIL busy_status got=%h exp=81", d); end
        send_byte(8'h3C, 1'b1, ok);
        drain(23, n);
        checks++;
        if (n !== 23) begin failures++; $display("FAIL busy_len got=%0d exp=23", n); end
        for (int i = 0; i < 23; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL busy_byte%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
        read_reg(REG_STAT, d);
        checks++;
        if (d !== 8'h40) begin failures++; $display("FAIL busy_done got=%h exp=40", d); end
    endtask

    task automatic test_reset_mid_trailer();
        byte_t exp [14];
        byte_t d;
        bit ok;
        int n;
        exp = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        do_reset();
        bus_write(REG_WLO, 8'h01);
        bus_write(REG_HLO, 8'h01);
        bus_write(REG_CTRL, 8'h80);
        wait_ready(ok);
        for (int i = 0; i < 5; i++) read_reg(REG_FIFO, d);
        send_byte(8'h99, 1'b1, ok);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = REG_CNT;
        #1 d = bus.data_o;
        bus.cs = 1'b0;
        checks++;
        if (d !== 8'd13) begin failures++; $display("FAIL rst_pre_count got=%0d exp=13", d); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.addr = REG_STAT;
        #1;
        checks++;
        if (bus.data_o !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", bus.data_o); end
        bus.addr = REG_CNT;
        #1;
        checks++;
        if (bus.data_o !== 8'h00) begin failures++; $display("FAIL rst_count got=%h exp=00", bus.data_o); end
        checks++;
        if (bus.enc_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.enc_ready); end
        bus_write(REG_CTRL, 8'h80);
        drain(14, n);
        checks++;
        if (n !== 14) begin failures++; $display("FAIL rst_hdr_len got=%0d exp=14", n); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++;
                $display("FAIL rst_hdr%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        bus.cs = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.data_i = '0;
        bus.enc_data = '0;
        bus.enc_valid = 1'b0;
        bus.enc_last = 1'b0;
        test_reset();
        test_frame();
        test_full();
        test_empty_read();
        test_push_pop();
        test_start_while_busy();
        test_reset_mid_trailer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
